alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//  Multi-cycle unsigned 32x32->64 shift-add multiplier. It acts as the initiator on the
//  ALU operand/control interface, driving ALUControl, input1 and input2 and sampling ALUOut.
//  It has no adder of its own: every addition and carry check runs as an ALU operation.
//  It sits beside the datapath ALU and is selected by the execute-stage mux while busy.
// PARAMETERS
//  WIDTH   32       operand width; product is 2*WIDTH
//  OP_ADD  4'b0010  ALUControl code for sum
//  OP_SLT  4'b0111  ALUControl code for unsigned less-than (result bit 0)
//  OP_NOP  4'b1111  ALUControl code driven when the ALU is unused (ALU default -> 0)
// PORTS
//  clock         in   1        rising-edge clock
//  reset         in   1        asynchronous, active-high reset
//  start         in   1        request; sampled only in IDLE
//  multiplicand  in   WIDTH    operand A; captured on accepted start
//  multiplier    in   WIDTH    operand B; captured on accepted start
//  busy          out  1        high in every state except IDLE
//  done          out  1        one-cycle pulse; product valid from this cycle
//  product       out  2*WIDTH  result; held until the next accepted start
//  alu_control   out  4        to ALU ALUControl
//  alu_in1       out  WIDTH    to ALU input1
//  alu_in2       out  WIDTH    to ALU input2
//  alu_result    in   WIDTH    from ALU ALUOut (combinational, same cycle)
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, done=0, product=0; internal A, P_hi, Q, carry, count=0.
//  ALU outputs decode combinationally from state: ADD -> OP_ADD, in1=P_hi, in2=A;
//   CARRY -> OP_SLT, in1=T, in2=P_hi; all other states -> OP_NOP, in1=0, in2=0.
//  IDLE: if start, load A=multiplicand, Q=multiplier, P_hi=0, carry=0, count=0.
//   Next state is ADD if multiplier[0]=1, else SHIFT. Without start, stay in IDLE.
//  ADD: T <= alu_result (P_hi+A mod 2^WIDTH) -> CARRY.
//  CARRY: carry <= alu_result[0] (T < P_hi unsigned), P_hi <= T -> SHIFT.
//  SHIFT: {carry,P_hi,Q} <= {1'b0,carry,P_hi,Q} >> 1, i.e. a logical right shift by one
//   with carry entering P_hi[WIDTH-1]; then count <= count+1.
//   If count==WIDTH-1, go to DONE. Otherwise go to ADD if the new Q[0]=1, else SHIFT.
//  DONE: product <= {P_hi,Q} on entry; done=1 for exactly this cycle -> IDLE.
//  Latency: start accepted at cycle T0; DONE at T0+1+WIDTH+2k, where k is the
//   popcount of the multiplier. Range: T0+33 (k=0) to T0+97 (k=32).
//  start while busy (including the DONE cycle) is ignored, and the operands are not recaptured.
//  Operand inputs may change after acceptance without effect.
//  product holds its previous value during an operation and updates only on entry to DONE.
//  Reset asserted mid-operation aborts immediately: no done pulse, product=0.
//   The ALU outputs return to OP_NOP/0.
//  Unsigned only; no overflow possible (2*WIDTH-bit result).
//  count is $clog2(WIDTH) bits wide and never wraps: DONE is reached at count==WIDTH-1.
// TESTING
//  3 x 5 (k=2): start at T0 -> done at T0+37, product=64'd15, busy low at T0+38.
//  0xFFFFFFFF x 0xFFFFFFFF -> done at T0+97, product=64'hFFFFFFFE_00000001.
//   Every CARRY cycle after the first sees alu_result=1.
//  0x12345678 x 0 -> done at T0+33, product=0; alu_control never equals 4'b0010.
//  Start 7x9, pulse start with 2x2 at T0+10 and at the DONE cycle.
//   Required: product=63, one done pulse, next start accepted only from IDLE.
//  Assert reset at T0+20 of 0xFFFF x 0xFFFF -> busy=0 and done=0 asynchronously, product=0.
//   A following 6x7 yields 42 with normal latency.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier that borrows the datapath
// ALU for every addition and carry detection instead of carrying its own adder.
module alu_mul_sequencer #(
  parameter int          WIDTH  = 32,
  parameter logic [3:0]  OP_ADD = 4'b0010,
  parameter logic [3:0]  OP_SLT = 4'b0111,
  parameter logic [3:0]  OP_NOP = 4'b1111
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [3:0]           alu_control,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  input  logic [WIDTH-1:0]     alu_result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_CARRY = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Handshake: start is a level request honoured only while idle; there is no
  // backpressure on the result, done is a single-cycle pulse and product is held.
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     p_hi_q, p_hi_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     t_q, t_d;
  logic                 carry_q, carry_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    p_hi_d    = p_hi_q;
    q_d       = q_q;
    t_d       = t_q;
    carry_d   = carry_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = multiplicand;
          q_d     = multiplier;
          p_hi_d  = '0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = multiplier[0] ? S_ADD : S_SHIFT;
        end
      end
      S_ADD: begin
        t_d     = alu_result;
        state_d = S_CARRY;
      end
      S_CARRY: begin
        // The sum wrapped iff it came out smaller than the addend it started from.
        carry_d = alu_result[0];
        p_hi_d  = t_q;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        p_hi_d  = {carry_q, p_hi_q[WIDTH-1:1]};
        q_d     = {p_hi_q[0], q_q[WIDTH-1:1]};
        carry_d = 1'b0;
        if (count_q == LAST_COUNT) begin
          product_d = {p_hi_d, q_d};
          state_d   = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = q_q[1] ? S_ADD : S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      p_hi_q    <= '0;
      q_q       <= '0;
      t_q       <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      p_hi_q    <= p_hi_d;
      q_q       <= q_d;
      t_q       <= t_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    alu_control = OP_NOP;
    alu_in1     = '0;
    alu_in2     = '0;
    case (state_q)
      S_ADD: begin
        alu_control = OP_ADD;
        alu_in1     = p_hi_q;
        alu_in2     = a_q;
      end
      S_CARRY: begin
        alu_control = OP_SLT;
        alu_in1     = t_q;
        alu_in2     = p_hi_q;
      end
      default: begin
        alu_control = OP_NOP;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural ALU beside the DUT, products and
// latencies predicted from plain arithmetic, randomized and directed operands.
module tb_alu_mul_sequencer;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy, done;
  logic [63:0] product;
  logic [3:0]  alu_control;
  logic [31:0] alu_in1, alu_in2, alu_result;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_p;

  // Observations gathered by run_op for the calling test to judge.
  int          obs_first_done, obs_done_pulses, obs_busy_gap, obs_alu_bad;
  int          obs_add, obs_slt, obs_slt_ones, obs_prod_glitch;
  logic        obs_busy_after;
  logic [63:0] obs_product;

  alu_mul_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result)
  );

  always #5 clock = ~clock;

  always_comb begin
    alu_result = '0;
    case (alu_control)
      OP_ADD:  alu_result = alu_in1 + alu_in2;
      OP_SLT:  alu_result = 32'(alu_in1 < alu_in2);
      default: alu_result = '0;
    endcase
  end

  function automatic int exp_lat(input logic [31:0] b);
    return 33 + 2 * $countones(b);
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int pulse_m, input bit pulse_done);
    logic [63:0] prev_product;
    int m;
    obs_first_done = -1; obs_done_pulses = 0; obs_busy_gap = 0; obs_alu_bad = 0;
    obs_add = 0; obs_slt = 0; obs_slt_ones = 0; obs_prod_glitch = 0;
    obs_busy_after = 1'b1; obs_product = '0;
    @(negedge clock);
    prev_product = product;
    multiplicand = a; multiplier = b; start = 1'b1;
    m = 0;
    while (m < 150) begin
      @(negedge clock);
      m++;
      start = 1'b0;
      multiplicand = $urandom; multiplier = $urandom;
      if (done) begin
        obs_done_pulses++;
        if (obs_first_done < 0) begin
          obs_first_done = m;
          obs_product = product;
        end
      end
      if (obs_first_done < 0) begin
        if (!busy) obs_busy_gap++;
        if (product !== prev_product) obs_prod_glitch++;
      end
      if (alu_control === OP_ADD) begin
        obs_add++;
        if (alu_in2 !== a) obs_alu_bad++;
      end else if (alu_control === OP_SLT) begin
        obs_slt++;
        if (alu_result[0]) obs_slt_ones++;
      end else if (alu_control !== OP_NOP || alu_in1 !== '0 || alu_in2 !== '0) begin
        obs_alu_bad++;
      end
      if (m == pulse_m || (pulse_done && done)) begin
        start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
      end
      if (obs_first_done >= 0 && m == obs_first_done + 1) begin
        obs_busy_after = busy;
        if (product !== obs_product) obs_prod_glitch++;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (product !== 64'd0) begin n_errors++; $display("FAIL reset_product: got %h expected 0", product); end
    n_checks++;
    if (alu_control !== OP_NOP || alu_in1 !== '0 || alu_in2 !== '0) begin
      n_errors++;
      $display("FAIL reset_alu: got ctl=%h in1=%h in2=%h expected f/0/0", alu_control, alu_in1, alu_in2);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] av[3];
    logic [31:0] bv[3];
    av[0] = 32'd3;        bv[0] = 32'd5;
    av[1] = 32'hFFFFFFFF; bv[1] = 32'hFFFFFFFF;
    av[2] = 32'h12345678; bv[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(64'(av[i]) * 64'(bv[i]));
      run_op(av[i], bv[i], -1, 1'b0);
      exp_p = exp_q.pop_front();
      n_checks++;
      if (obs_product !== exp_p) begin n_errors++; $display("FAIL dir%0d_product: got %h expected %h", i, obs_product, exp_p); end
      n_checks++;
      if (obs_first_done != exp_lat(bv[i])) begin n_errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, obs_first_done, exp_lat(bv[i])); end
      n_checks++;
      if (obs_busy_after !== 1'b0) begin n_errors++; $display("FAIL dir%0d_busy_after: got %b expected 0", i, obs_busy_after); end
      n_checks++;
      if (obs_done_pulses != 1) begin n_errors++; $display("FAIL dir%0d_done_pulses: got %0d expected 1", i, obs_done_pulses); end
      n_checks++;
      if (obs_add != $countones(bv[i]) || obs_slt != $countones(bv[i])) begin
        n_errors++;
        $display("FAIL dir%0d_alu_ops: got add=%0d slt=%0d expected %0d", i, obs_add, obs_slt, $countones(bv[i]));
      end
      n_checks++;
      if (obs_alu_bad != 0 || obs_busy_gap != 0 || obs_prod_glitch != 0) begin
        n_errors++;
        $display("FAIL dir%0d_protocol: got alu_bad=%0d busy_gap=%0d glitch=%0d expected 0", i, obs_alu_bad, obs_busy_gap, obs_prod_glitch);
      end
    end
    // All-ones operands: the very first accumulation cannot carry, all later ones do.
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    n_checks++;
    if (obs_slt_ones != 31) begin n_errors++; $display("FAIL ones_carry_count: got %0d expected 31", obs_slt_ones); end
  endtask

  task automatic test_start_ignored();
    exp_q.push_back(64'd63);
    run_op(32'd7, 32'd9, 10, 1'b1);
    exp_p = exp_q.pop_front();
    n_checks++;
    if (obs_product !== exp_p) begin n_errors++; $display("FAIL ign_product: got %h expected %h", obs_product, exp_p); end
    n_checks++;
    if (obs_first_done != exp_lat(32'd9)) begin n_errors++; $display("FAIL ign_latency: got %0d expected %0d", obs_first_done, exp_lat(32'd9)); end
    n_checks++;
    if (obs_done_pulses != 1) begin n_errors++; $display("FAIL ign_done_pulses: got %0d expected 1", obs_done_pulses); end
    n_checks++;
    if (obs_busy_after !== 1'b0) begin n_errors++; $display("FAIL ign_busy_after: got %b expected 0", obs_busy_after); end
    n_checks++;
    if (obs_prod_glitch != 0) begin n_errors++; $display("FAIL ign_product_hold: got %0d changes expected 0", obs_prod_glitch); end
    exp_q.push_back(64'd4);
    run_op(32'd2, 32'd2, -1, 1'b0);
    exp_p = exp_q.pop_front();
    n_checks++;
    if (obs_product !== exp_p || obs_first_done != exp_lat(32'd2)) begin
      n_errors++;
      $display("FAIL ign_next_op: got %h at %0d expected %h at %0d", obs_product, obs_first_done, exp_p, exp_lat(32'd2));
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clock);
    multiplicand = 32'hFFFF; multiplier = 32'hFFFF; start = 1'b1;
    repeat (20) begin
      @(negedge clock);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL abort_flags: got busy=%b done=%b expected 0/0", busy, done); end
    n_checks++;
    if (product !== 64'd0) begin n_errors++; $display("FAIL abort_product: got %h expected 0", product); end
    n_checks++;
    if (alu_control !== OP_NOP || alu_in1 !== '0 || alu_in2 !== '0) begin
      n_errors++;
      $display("FAIL abort_alu: got ctl=%h in1=%h in2=%h expected f/0/0", alu_control, alu_in1, alu_in2);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(64'd42);
    run_op(32'd6, 32'd7, -1, 1'b0);
    exp_p = exp_q.pop_front();
    n_checks++;
    if (obs_product !== exp_p || obs_first_done != exp_lat(32'd7)) begin
      n_errors++;
      $display("FAIL abort_next_op: got %h at %0d expected %h at %0d", obs_product, obs_first_done, exp_p, exp_lat(32'd7));
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = $urandom & $urandom & $urandom; end
        2: begin a = 32'hFFFFFFFF; b = $urandom; end
        default: begin a = $urandom; b = $urandom | $urandom; end
      endcase
      exp_q.push_back(64'(a) * 64'(b));
      run_op(a, b, -1, 1'b0);
      exp_p = exp_q.pop_front();
      n_checks++;
      if (obs_product !== exp_p) begin n_errors++; $display("FAIL rnd%0d_product: a=%h b=%h got %h expected %h", i, a, b, obs_product, exp_p); end
      n_checks++;
      if (obs_first_done != exp_lat(b)) begin n_errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, obs_first_done, exp_lat(b)); end
      n_checks++;
      if (obs_done_pulses != 1 || obs_busy_after !== 1'b0 || obs_busy_gap != 0) begin
        n_errors++;
        $display("FAIL rnd%0d_handshake: got pulses=%0d busy_after=%b gap=%0d expected 1/0/0", i, obs_done_pulses, obs_busy_after, obs_busy_gap);
      end
      n_checks++;
      if (obs_alu_bad != 0 || obs_add != $countones(b) || obs_prod_glitch != 0) begin
        n_errors++;
        $display("FAIL rnd%0d_alu: got bad=%0d add=%0d glitch=%0d expected 0/%0d/0", i, obs_alu_bad, obs_add, obs_prod_glitch, $countones(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
